// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit.
package mips_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_iterative_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
interface mdu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: magnitude on entry, sign restore on exit.
module mdu_sign_fix #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_val,
  input  logic         i_neg,
  output logic [N-1:0] o_val
);

  assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers (32 steps + sign fix).
// Optional macro MDU_FAST_MUL_EN: single-cycle multiplies via an inferred multiplier.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo accepted here
// CALC  | one shift-add or restoring-divide step per cycle
// FIX   | sign correction and HI/LO write
module mdu_iterative
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  mdu_iterative_if.slave mdu
);

  mdu_state_e r_state;
  mdu_state_e w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [2*WIDTH:0] r_acc;
  logic [WIDTH-1:0] r_opnd_b;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  mdu_op_e          w_op;
  logic             w_signed;
  logic             w_op_div;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_fast_mul;
  logic             w_start_iter;

  assign w_op     = mdu_op_e'(mdu.op);
  assign w_signed = (w_op == MDU_MULT) || (w_op == MDU_DIV);
  assign w_op_div = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
  assign w_neg_a  = w_signed & mdu.rs_data[WIDTH-1];
  assign w_neg_b  = w_signed & mdu.rt_data[WIDTH-1];

  mdu_sign_fix #(.N(WIDTH)) u_abs_a (.i_val(mdu.rs_data), .i_neg(w_neg_a), .o_val(w_mag_a));
  mdu_sign_fix #(.N(WIDTH)) u_abs_b (.i_val(mdu.rt_data), .i_neg(w_neg_b), .o_val(w_mag_b));

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_fast_prod;

  // Sign-extending to 2*WIDTH lets one multiplier serve both MULT and MULTU.
  assign w_ext_a     = {{WIDTH{w_neg_a}}, mdu.rs_data};
  assign w_ext_b     = {{WIDTH{w_neg_b}}, mdu.rt_data};
  assign w_fast_prod = w_ext_a * w_ext_b;
  assign w_fast_mul  = mdu.start && (r_state == IDLE) && !w_op_div;
`else
  assign w_fast_mul  = 1'b0;
`endif

  assign w_start_iter = mdu.start && (r_state == IDLE) && !w_fast_mul;

  // Multiply step: conditional add into the upper half, then shift right.
  logic [WIDTH:0]   w_mul_sum;
  logic [2*WIDTH:0] w_mul_nxt;
  assign w_mul_sum = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_opnd_b} : '0);
  assign w_mul_nxt = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: upper half is the remainder, lower half shifts the
  // dividend out while quotient bits shift in.
  logic [2*WIDTH:0] w_div_shl;
  logic [WIDTH:0]   w_rem_trial;
  logic [WIDTH:0]   w_rem_sub;
  logic             w_div_ge;
  logic [2*WIDTH:0] w_div_nxt;
  assign w_div_shl   = {r_acc[2*WIDTH-1:0], 1'b0};
  assign w_rem_trial = w_div_shl[2*WIDTH:WIDTH];
  assign w_div_ge    = w_rem_trial >= {1'b0, r_opnd_b};
  assign w_rem_sub   = w_rem_trial - {1'b0, r_opnd_b};
  assign w_div_nxt   = w_div_ge ? {w_rem_sub, w_div_shl[WIDTH-1:1], 1'b1} : w_div_shl;

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  mdu_sign_fix #(.N(2*WIDTH)) u_fix_prod (
    .i_val(r_acc[2*WIDTH-1:0]), .i_neg(r_neg_q), .o_val(w_prod_fix)
  );
  mdu_sign_fix #(.N(WIDTH)) u_fix_quo (
    .i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_q), .o_val(w_quo_fix)
  );
  mdu_sign_fix #(.N(WIDTH)) u_fix_rem (
    .i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_r), .o_val(w_rem_fix)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_iter) w_state_nxt = CALC;
      CALC:    if (r_cnt == CNT_W'(WIDTH-1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mdu.busy = (r_state != IDLE);
    mdu.done = r_done;
    mdu.hi   = r_hi;
    mdu.lo   = r_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd_b   <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_iter) begin
            r_cnt      <= '0;
            r_acc      <= {{(WIDTH+1){1'b0}}, w_mag_a};
            r_opnd_b   <= w_mag_b;
            r_is_div   <= w_op_div;
            r_neg_q    <= w_neg_a ^ w_neg_b;
            r_neg_r    <= w_neg_a;
            r_div_zero <= (mdu.rt_data == '0);
`ifdef MDU_FAST_MUL_EN
          end else if (w_fast_mul) begin
            r_hi   <= w_fast_prod[2*WIDTH-1:WIDTH];
            r_lo   <= w_fast_prod[WIDTH-1:0];
            r_done <= 1'b1;
`endif
          end else begin
            if (mdu.mthi) r_hi <= mdu.rs_data;
            if (mdu.mtlo) r_lo <= mdu.rs_data;
          end
        end
        CALC: begin
          r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          // Divide by zero leaves the remainder equal to the dividend, so only
          // the quotient needs forcing to all ones.
          if (r_is_div) begin
            r_lo <= r_div_zero ? '1 : w_quo_fix;
            r_hi <= w_rem_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
